pump_zone_scheduler: RTL and testbench

Shares the single watering pump motor between NZONES plant zones, each with its own valve.
- Per zone: a programmable watering interval and on-time, both in seconds.
- When a zone's interval expires, the zone is queued.
- A round-robin arbiter grants the pump to one queued zone at a time, then enforces a pump-off settle gap before the next grant.
- Sits between the switch/config front end and the GPIO motor and valve drivers.

---
 rtl/pump_zone_if.sv | 41 ++++
 rtl/pump_zone_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_pump_zone_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pump_zone_if.sv
// Pump scheduler bus: config write port from the switch/config front end and
// the motor/valve/status outputs toward the GPIO drivers.
//   cfg_we/cfg_zone/cfg_interval/cfg_on_time : one-cycle zone config write
//   manual_req                               : per-zone manual request level
//                                              (only with PUMP_SCHED_MANUAL_EN)
//   pump_n, valve_en, busy, active_zone      : drive and state outputs
//   pending, overrun                         : request queue status
// master = front end / bench side, slave = scheduler side.
interface pump_zone_if #(
    parameter int unsigned NZONES = 4
);
    logic              cfg_we;
    logic [2:0]        cfg_zone;
    logic [15:0]       cfg_interval;
    logic [7:0]        cfg_on_time;
`ifdef PUMP_SCHED_MANUAL_EN
    logic [NZONES-1:0] manual_req;
`endif
    logic              pump_n;
    logic [NZONES-1:0] valve_en;
    logic              busy;
    logic [2:0]        active_zone;
    logic [NZONES-1:0] pending;
    logic [NZONES-1:0] overrun;

    modport master (
`ifdef PUMP_SCHED_MANUAL_EN
        output manual_req,
`endif
        output cfg_we, cfg_zone, cfg_interval, cfg_on_time,
        input  pump_n, valve_en, busy, active_zone, pending, overrun
    );

    modport slave (
`ifdef PUMP_SCHED_MANUAL_EN
        input  manual_req,
`endif
        input  cfg_we, cfg_zone, cfg_interval, cfg_on_time,
        output pump_n, valve_en, busy, active_zone, pending, overrun
    );
endinterface

// File: rtl/pump_zone_scheduler.sv
// Shares one watering pump between NZONES valve zones. Each zone has a
// programmable interval and on-time (seconds); expired zones are queued and
// granted round-robin, with a pump-off settle gap after every run.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-low
//   bus      : pump_zone_if slave (config in, pump/valve/status out)
// Optional feature macro: PUMP_SCHED_MANUAL_EN adds manual_req with
// priority over timer-only requests.
// All outputs are registered.
module pump_zone_scheduler #(
    parameter int unsigned NZONES       = 4,
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned SETTLE_TICKS = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    pump_zone_if.slave bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ZW = 3;

    typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

    state_t            state_q, state_nxt;
    logic [PW-1:0]     presc_q, presc_nxt;
    logic              tick;
    logic [15:0]       interval_q [NZONES];
    logic [15:0]       interval_nxt [NZONES];
    logic [15:0]       cnt_q [NZONES];
    logic [15:0]       cnt_nxt [NZONES];
    logic [7:0]        on_time_q [NZONES];
    logic [7:0]        on_time_nxt [NZONES];
    logic [7:0]        on_cnt_q, on_cnt_nxt;
    logic [7:0]        settle_q, settle_nxt;
    logic [7:0]        on_sel;
    logic [NZONES-1:0] pending_q, pending_nxt;
    logic [NZONES-1:0] overrun_q, overrun_nxt;
    logic [NZONES-1:0] valve_q, valve_nxt;
    logic [NZONES-1:0] req;
    logic [NZONES-1:0] arb_mask;
    logic [ZW-1:0]     rr_q, rr_nxt;
    logic [ZW-1:0]     active_q, active_nxt;
    logic              pump_n_q, pump_n_nxt;
    logic              busy_q, busy_nxt;
    logic              grant;
    logic [ZW-1:0]     gnt_idx;
    logic              hi_found, lo_found;
    logic [ZW-1:0]     hi_idx, lo_idx;
`ifdef PUMP_SCHED_MANUAL_EN
    logic [NZONES-1:0] man_prev_q;
    logic [NZONES-1:0] man_q, man_nxt;
    logic [NZONES-1:0] man_rise;
`endif

    // Arbitration mask: manual requests (if enabled) win over timer-only ones.
    always_comb begin
`ifdef PUMP_SCHED_MANUAL_EN
        man_rise = bus.manual_req & ~man_prev_q;
        if ((pending_q & man_q) != '0) arb_mask = pending_q & man_q;
        else                           arb_mask = pending_q;
`else
        arb_mask = pending_q;
`endif
    end

    // Round-robin pick: lowest set bit at or above rr_ptr, else lowest below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int z = int'(NZONES) - 1; z >= 0; z--) begin
            if (arb_mask[z] && (z >= int'(rr_q))) begin
                hi_found = 1'b1;
                hi_idx   = ZW'(z);
            end
            if (arb_mask[z] && (z < int'(rr_q))) begin
                lo_found = 1'b1;
                lo_idx   = ZW'(z);
            end
        end
        grant   = (state_q == IDLE) && (hi_found || lo_found);
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    // Next-state, timers, request queue and registered output values.
    always_comb begin
        state_nxt  = state_q;
        on_cnt_nxt = on_cnt_q;
        settle_nxt = settle_q;
        rr_nxt     = rr_q;
        active_nxt = active_q;
        on_sel     = '0;
        req        = '0;
`ifdef PUMP_SCHED_MANUAL_EN
        man_nxt    = man_q;
`endif

        tick      = (presc_q == PW'(TICK_DIV - 1));
        presc_nxt = tick ? '0 : presc_q + PW'(1);

        for (int z = 0; z < int'(NZONES); z++) begin
            interval_nxt[z] = interval_q[z];
            on_time_nxt[z]  = on_time_q[z];
            cnt_nxt[z]      = cnt_q[z];
            pending_nxt[z]  = pending_q[z];
            overrun_nxt[z]  = overrun_q[z];

            // Zone timer; disabled zones hold at 0, no wrap below 1.
            if (tick && (interval_q[z] != 16'd0)) begin
                if (cnt_q[z] == 16'd1) begin
                    cnt_nxt[z] = interval_q[z];
                    req[z]     = 1'b1;
                end else if (cnt_q[z] > 16'd1) begin
                    cnt_nxt[z] = cnt_q[z] - 16'd1;
                end
            end
`ifdef PUMP_SCHED_MANUAL_EN
            if (man_rise[z]) begin
                req[z]     = 1'b1;
                man_nxt[z] = 1'b1;
            end
`endif

            if (grant && (gnt_idx == ZW'(z))) begin
                pending_nxt[z] = 1'b0;
                on_sel         = on_time_q[z];
`ifdef PUMP_SCHED_MANUAL_EN
                if (!man_rise[z]) man_nxt[z] = 1'b0;
`endif
            end

            // A request for the zone being granted re-queues without overrun.
            if (req[z]) begin
                if (pending_q[z] && !(grant && (gnt_idx == ZW'(z))))
                    overrun_nxt[z] = 1'b1;
                else
                    pending_nxt[z] = 1'b1;
            end

            // Config write takes precedence over this cycle's timer activity.
            if (bus.cfg_we && (bus.cfg_zone == ZW'(z))) begin
                interval_nxt[z] = bus.cfg_interval;
                on_time_nxt[z]  = bus.cfg_on_time;
                cnt_nxt[z]      = bus.cfg_interval;
                overrun_nxt[z]  = 1'b0;
                if (bus.cfg_interval == 16'd0) begin
                    pending_nxt[z] = 1'b0;
`ifdef PUMP_SCHED_MANUAL_EN
                    man_nxt[z]     = 1'b0;
`endif
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_nxt  = RUN;
                    active_nxt = gnt_idx;
                    rr_nxt     = (gnt_idx == ZW'(NZONES - 1)) ? '0 : gnt_idx + ZW'(1);
                    on_cnt_nxt = (on_sel == 8'd0) ? 8'd1 : on_sel;
                end
            end
            RUN: begin
                if (tick) begin
                    if (on_cnt_q <= 8'd1) begin
                        state_nxt  = SETTLE;
                        settle_nxt = 8'(SETTLE_TICKS);
                    end else begin
                        on_cnt_nxt = on_cnt_q - 8'd1;
                    end
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (settle_q <= 8'd1) state_nxt  = IDLE;
                    else                  settle_nxt = settle_q - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs derive from the next state so pump and valve switch together.
        pump_n_nxt = (state_nxt != RUN);
        busy_nxt   = (state_nxt != IDLE);
        for (int z = 0; z < int'(NZONES); z++)
            valve_nxt[z] = (state_nxt == RUN) && (active_nxt == ZW'(z));
    end

    // State and register update.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            on_cnt_q  <= '0;
            settle_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            valve_q   <= '0;
            rr_q      <= '0;
            active_q  <= '0;
            pump_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            for (int z = 0; z < int'(NZONES); z++) begin
                interval_q[z] <= '0;
                on_time_q[z]  <= '0;
                cnt_q[z]      <= '0;
            end
`ifdef PUMP_SCHED_MANUAL_EN
            man_prev_q <= '0;
            man_q      <= '0;
`endif
        end else begin
            state_q   <= state_nxt;
            presc_q   <= presc_nxt;
            on_cnt_q  <= on_cnt_nxt;
            settle_q  <= settle_nxt;
            pending_q <= pending_nxt;
            overrun_q <= overrun_nxt;
            valve_q   <= valve_nxt;
            rr_q      <= rr_nxt;
            active_q  <= active_nxt;
            pump_n_q  <= pump_n_nxt;
            busy_q    <= busy_nxt;
            for (int z = 0; z < int'(NZONES); z++) begin
                interval_q[z] <= interval_nxt[z];
                on_time_q[z]  <= on_time_nxt[z];
                cnt_q[z]      <= cnt_nxt[z];
            end
`ifdef PUMP_SCHED_MANUAL_EN
            man_prev_q <= bus.manual_req;
            man_q      <= man_nxt;
`endif
        end
    end

    assign bus.pump_n      = pump_n_q;
    assign bus.valve_en    = valve_q;
    assign bus.busy        = busy_q;
    assign bus.active_zone = active_q;
    assign bus.pending     = pending_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pump_zone_scheduler.sv
// Directed bench for pump_zone_scheduler with NZONES=4, TICK_DIV=4,
// SETTLE_TICKS=1. Edge numbers E<n> count rising edges after reset release;
// ticks land on E4, E8, E12, ...
module tb_pump_zone_scheduler;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ecount   = 0;
    logic mon_en   = 1'b0;
    logic two_hot_seen;
    logic z1_seen;

    pump_zone_if #(.NZONES(4)) bus ();

    pump_zone_scheduler #(
        .NZONES(4),
        .TICK_DIV(4),
        .SETTLE_TICKS(1)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Valve-exclusivity and zone1-activity watcher, armed per test.
    always @(negedge CLOCK_50) begin
        if (!mon_en) begin
            two_hot_seen <= 1'b0;
            z1_seen      <= 1'b0;
        end else begin
            if ($countones(bus.valve_en) > 1) two_hot_seen <= 1'b1;
            if (bus.valve_en[1])              z1_seen      <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            ecount++;
        end
    endtask

    task automatic step_to(input int e);
        while (ecount < e) step(1);
    endtask

    task automatic cfg(input logic [2:0] zone, input logic [15:0] intv, input logic [7:0] on_t);
        bus.cfg_we       = 1'b1;
        bus.cfg_zone     = zone;
        bus.cfg_interval = intv;
        bus.cfg_on_time  = on_t;
        step(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        bus.cfg_we = 1'b0;
        step(2);
        reset  = 1'b1;
        ecount = 0;
    endtask

    initial begin
        bus.cfg_we       = 1'b0;
        bus.cfg_zone     = '0;
        bus.cfg_interval = '0;
        bus.cfg_on_time  = '0;
`ifdef PUMP_SCHED_MANUAL_EN
        bus.manual_req   = '0;
`endif

        // Reset state
        reset = 1'b0;
        step(3);
        check("rst_pump_n",  32'(bus.pump_n), 32'd1);
        check("rst_valve",   32'(bus.valve_en), 32'd0);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_active",  32'(bus.active_zone), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // Test 1: single zone, interval 3 s, on-time 2 s
        reset  = 1'b1;
        ecount = 0;
        cfg(3'd0, 16'd3, 8'd2);                      // E1
        step_to(11);
        check("t1_pend_early", 32'(bus.pending), 32'd0);
        step_to(12);
        check("t1_pend_rise", 32'(bus.pending), 32'd1);
        check("t1_pump_idle", 32'(bus.pump_n), 32'd1);
        step_to(13);
        check("t1_run_pump",  32'(bus.pump_n), 32'd0);
        check("t1_run_valve", 32'(bus.valve_en), 32'd1);
        check("t1_run_busy",  32'(bus.busy), 32'd1);
        check("t1_run_pend",  32'(bus.pending), 32'd0);
        step_to(19);
        check("t1_run_last",  32'(bus.pump_n), 32'd0);
        step_to(20);
        check("t1_set_pump",  32'(bus.pump_n), 32'd1);
        check("t1_set_valve", 32'(bus.valve_en), 32'd0);
        check("t1_set_busy",  32'(bus.busy), 32'd1);
        step_to(23);
        check("t1_set_last",  32'(bus.busy), 32'd1);
        step_to(24);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_pend", 32'(bus.pending), 32'd1);
        step_to(25);
        check("t1_rerun_valve", 32'(bus.valve_en), 32'd1);
        check("t1_rerun_pump",  32'(bus.pump_n), 32'd0);

        // Test 4: one-cycle reset mid-RUN
        reset = 1'b0;
        step(1);
        check("t4_pump",  32'(bus.pump_n), 32'd1);
        check("t4_valve", 32'(bus.valve_en), 32'd0);
        check("t4_pend",  32'(bus.pending), 32'd0);
        check("t4_busy",  32'(bus.busy), 32'd0);
        reset = 1'b1;
        step(20);
        check("t4_quiet_pend", 32'(bus.pending), 32'd0);
        check("t4_quiet_busy", 32'(bus.busy), 32'd0);

        // Test 2: all zones due on the same tick
        do_reset();
        step_to(3);
        cfg(3'd0, 16'd2, 8'd1);                      // E4 (config beats tick)
        cfg(3'd1, 16'd2, 8'd1);                      // E5
        cfg(3'd2, 16'd2, 8'd1);                      // E6
        cfg(3'd3, 16'd2, 8'd1);                      // E7
        mon_en = 1'b1;
        step_to(11);
        check("t2_pend_early", 32'(bus.pending), 32'd0);
        step_to(12);
        check("t2_pend_all", 32'(bus.pending), 32'hf);
        step_to(13);
        check("t2_g0_valve",  32'(bus.valve_en), 32'h1);
        check("t2_g0_active", 32'(bus.active_zone), 32'd0);
        step_to(16);
        check("t2_set_valve", 32'(bus.valve_en), 32'h0);
        check("t2_set_pump",  32'(bus.pump_n), 32'd1);
        step_to(20);
        check("t2_e20_pend", 32'(bus.pending), 32'hf);
        check("t2_e20_ovr",  32'(bus.overrun), 32'he);
        check("t2_e20_busy", 32'(bus.busy), 32'd0);
        step_to(21);
        check("t2_g1_valve",  32'(bus.valve_en), 32'h2);
        check("t2_g1_active", 32'(bus.active_zone), 32'd1);
        step_to(29);
        check("t2_g2_valve", 32'(bus.valve_en), 32'h4);
        step_to(37);
        check("t2_g3_valve",  32'(bus.valve_en), 32'h8);
        check("t2_g3_active", 32'(bus.active_zone), 32'd3);
        check("t2_g3_ovr",    32'(bus.overrun), 32'hf);
        check("t2_g3_pend",   32'(bus.pending), 32'h7);
        check("t2_one_hot",   32'(two_hot_seen), 32'd0);
        mon_en = 1'b0;

        // Test 3: overrun on a long run, cleared by config write
        do_reset();
        step_to(3);
        cfg(3'd1, 16'd1, 8'd5);                      // E4
        step_to(8);
        check("t3_pend", 32'(bus.pending), 32'h2);
        step_to(9);
        check("t3_run_valve", 32'(bus.valve_en), 32'h2);
        step_to(12);
        check("t3_requeue",  32'(bus.pending), 32'h2);
        check("t3_no_ovr",   32'(bus.overrun), 32'h0);
        step_to(16);
        check("t3_ovr_set",  32'(bus.overrun), 32'h2);
        cfg(3'd1, 16'd1, 8'd5);                      // E17
        check("t3_ovr_clr",  32'(bus.overrun), 32'h0);
        step_to(19);
        check("t3_ovr_hold", 32'(bus.overrun), 32'h0);
        step_to(20);
        check("t3_ovr_again", 32'(bus.overrun), 32'h2);
        step_to(27);
        check("t3_run_end",   32'(bus.pump_n), 32'd0);
        step_to(28);
        check("t3_settle",    32'(bus.pump_n), 32'd1);

        // Test 5: disabling a pending zone during another zone's SETTLE
        do_reset();
        step_to(3);
        cfg(3'd0, 16'd2, 8'd1);                      // E4
        cfg(3'd1, 16'd2, 8'd1);                      // E5
        mon_en = 1'b1;
        step_to(12);
        check("t5_pend_both", 32'(bus.pending), 32'h3);
        step_to(16);
        check("t5_settle_busy", 32'(bus.busy), 32'd1);
        check("t5_settle_pend", 32'(bus.pending), 32'h2);
        cfg(3'd1, 16'd0, 8'd1);                      // E17
        check("t5_pend_clr", 32'(bus.pending), 32'h0);
        step_to(20);
        check("t5_e20_pend", 32'(bus.pending), 32'h1);
        step_to(21);
        check("t5_g0_active", 32'(bus.active_zone), 32'd0);
        check("t5_g0_valve",  32'(bus.valve_en), 32'h1);
        step_to(60);
        check("t5_z1_never", 32'(z1_seen), 32'd0);
        check("t5_z1_pend",  32'(bus.pending[1]), 32'd0);
        mon_en = 1'b0;

`ifdef PUMP_SCHED_MANUAL_EN
        // Test 6: manual request jumps ahead of a timer request
        do_reset();
        step_to(3);
        cfg(3'd0, 16'd2, 8'd1);                      // E4
        step_to(11);
        bus.manual_req = 4'b0100;
        step(1);                                     // E12
        bus.manual_req = 4'b0000;
        check("t6_pend", 32'(bus.pending), 32'h5);
        step_to(13);
        check("t6_man_active", 32'(bus.active_zone), 32'd2);
        check("t6_man_valve",  32'(bus.valve_en), 32'h4);
        step_to(21);
        check("t6_tmr_active", 32'(bus.active_zone), 32'd0);
        check("t6_tmr_valve",  32'(bus.valve_en), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
